// File: rtl/job_fsm.sv
// ---------------------------------------------------------------------------
// job_fsm
//
// Purpose:
//   Runs one counting job at a time. A job starts from IDLE when go is seen.
//   On that edge the terminal count (limit) is captured. While ACTIVE, the
//   progress counter advances by STEP every cycle until the next step would
//   reach or pass the captured limit. The counter then saturates at the limit
//   and the FSM spends exactly one cycle in FINISH. A job can be paused
//   (hold) or aborted (kill). Kill always wins over hold.
//
// Parameters:
//   WIDTH  bit width of limit and count (default 8)
//   STEP   per-cycle increment of the progress counter, 1 .. 2^WIDTH-1
//
// Ports:
//   clk      in   single clock, all state changes on the rising edge
//   reset    in   synchronous, active-high reset
//   go       in   job start request (accepted in IDLE, and in FINISH when
//                 auto-restart is built in)
//   kill     in   abort request, level-sensitive
//   hold     in   pause request, level-sensitive
//   limit    in   terminal count, captured when go is accepted
//   done     out  high exactly while in FINISH
//   aborted  out  high exactly while in ABORT
//   busy     out  high while in ACTIVE or PAUSE
//   count    out  progress counter register
//
// Configuration macro:
//   JOB_FSM_AUTO_RESTART_EN  When defined, go=1 in FINISH starts the next job
//                            directly: limit is recaptured and count cleared.
//                            No IDLE cycle is inserted. When undefined,
//                            FINISH always returns to IDLE.
// ---------------------------------------------------------------------------
module job_fsm #(
  parameter int WIDTH = 8,
  parameter int STEP  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             kill,
  input  logic             hold,
  input  logic [WIDTH-1:0] limit,
  output logic             done,
  output logic             aborted,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_PAUSE  = 3'd2,
    S_FINISH = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  // The increment is held one bit wider than the counter. The terminal
  // compare then sees the true sum and never a wrapped value.
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q, aborted_q, busy_q;
  logic [WIDTH:0]   sum_d;

  // Next-state / next-count decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    sum_d   = {1'b0, count_q} + STEP_W;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (go) begin
          state_d = S_ACTIVE;
          limit_d = limit;
        end
      end

      S_ACTIVE: begin
        if (kill) begin
          state_d = S_ABORT;
        end else if (hold) begin
          state_d = S_PAUSE;
        end else if (sum_d >= {1'b0, limit_q}) begin
          // Saturate at the captured limit, so an overshooting step
          // never shows up on count.
          state_d = S_FINISH;
          count_d = limit_q;
        end else begin
          count_d = sum_d[WIDTH-1:0];
        end
      end

      S_PAUSE: begin
        if (kill) begin
          state_d = S_ABORT;
        end else if (!hold) begin
          state_d = S_ACTIVE;
        end
      end

      S_FINISH: begin
        count_d = '0;
`ifdef JOB_FSM_AUTO_RESTART_EN
        if (go) begin
          state_d = S_ACTIVE;
          limit_d = limit;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_ABORT: begin
        // The counter keeps its value on the edge that enters ABORT and
        // clears on the first edge spent in ABORT.
        count_d = '0;
        if (!kill) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        // Unused encodings recover to IDLE on the next edge.
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, counter, captured limit and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      // Flags are decoded from the next state. They therefore line up
      // exactly with state_q without a combinational output path.
      done_q    <= (state_d == S_FINISH);
      aborted_q <= (state_d == S_ABORT);
      busy_q    <= (state_d == S_ACTIVE) || (state_d == S_PAUSE);
    end
  end

  assign done    = done_q;
  assign aborted = aborted_q;
  assign busy    = busy_q;
  assign count   = count_q;

endmodule

// File: tb/tb_job_fsm.sv
// ---------------------------------------------------------------------------
// tb_job_fsm
//
// Scoreboard bench for job_fsm. The stimulus process drives inputs on the
// falling edge. It advances a job-level reference model and queues the
// outputs expected after the next rising edge. A separate monitor pops the
// queue shortly after each rising edge and compares the outputs.
//
// The model tracks a job as a number of completed ACTIVE steps k against
// a precomputed length N = max(1, ceil(limit/STEP)).
// ---------------------------------------------------------------------------
module tb_job_fsm;

  localparam int WIDTH = 8;
  localparam int STEP  = 20;

  logic             clk = 1'b0;
  logic             reset, go, kill, hold;
  logic [WIDTH-1:0] limit;
  logic             done, aborted, busy;
  logic [WIDTH-1:0] count;

  always #5 clk = ~clk;

  job_fsm #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .kill    (kill),
    .hold    (hold),
    .limit   (limit),
    .done    (done),
    .aborted (aborted),
    .busy    (busy),
    .count   (count)
  );

  typedef struct {
    int done;
    int aborted;
    int busy;
    int count;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // ---------------- reference model (job level) ----------------
  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_FINISH = 3;
  localparam int M_ABORT  = 4;

  int m_mode = M_IDLE;
  int m_lim  = 0;
  int m_k    = 0;
  int m_n    = 1;
  int m_acnt = 0;

  function automatic int job_len(input int lim);
    int n;
    n = (lim + STEP - 1) / STEP;
    return (n < 1) ? 1 : n;
  endfunction

  task automatic start_job(input int lim_in);
    m_mode = M_ACTIVE;
    m_lim  = lim_in;
    m_k    = 0;
    m_n    = job_len(lim_in);
  endtask

  task automatic model_step(input logic r, input logic g, input logic k,
                            input logic h, input int lim_in);
    exp_t e;
    if (r) begin
      m_mode = M_IDLE;
      m_lim  = 0;
      m_k    = 0;
      m_acnt = 0;
    end else begin
      case (m_mode)
        M_IDLE:   if (g) start_job(lim_in);
        M_ACTIVE: begin
          if (k) begin
            m_mode = M_ABORT;
            m_acnt = m_k * STEP;
          end else if (h) begin
            m_mode = M_PAUSE;
          end else begin
            m_k = m_k + 1;
            if (m_k >= m_n) m_mode = M_FINISH;
          end
        end
        M_PAUSE: begin
          if (k) begin
            m_mode = M_ABORT;
            m_acnt = m_k * STEP;
          end else if (!h) begin
            m_mode = M_ACTIVE;
          end
        end
        M_FINISH: begin
`ifdef JOB_FSM_AUTO_RESTART_EN
          if (g) start_job(lim_in);
          else   m_mode = M_IDLE;
`else
          m_mode = M_IDLE;
`endif
        end
        default: begin
          m_acnt = 0;
          if (!k) m_mode = M_IDLE;
        end
      endcase
    end
    e.done    = (m_mode == M_FINISH) ? 1 : 0;
    e.aborted = (m_mode == M_ABORT)  ? 1 : 0;
    e.busy    = (m_mode == M_ACTIVE || m_mode == M_PAUSE) ? 1 : 0;
    case (m_mode)
      M_ACTIVE, M_PAUSE: e.count = m_k * STEP;
      M_FINISH:          e.count = m_lim;
      M_ABORT:           e.count = m_acnt;
      default:           e.count = 0;
    endcase
    sb.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic g, input logic k,
                       input logic h, input int lim_in);
    @(negedge clk);
    reset = r;
    go    = g;
    kill  = k;
    hold  = h;
    limit = lim_in[WIDTH-1:0];
    model_step(r, g, k, h, lim_in);
  endtask

  task automatic idle_cycles(input int n, input int lim_noise);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, lim_noise);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done",    int'(done),    e.done);
        chk("aborted", int'(aborted), e.aborted);
        chk("busy",    int'(busy),    e.busy);
        chk("count",   int'(count),   e.count);
      end
    end
  end

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    kill  = 1'b0;
    hold  = 1'b0;
    limit = '0;

    // reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 55);

    // nominal, limit noise after capture must not matter
    drive(1'b0, 1'b1, 1'b0, 1'b0, 100);
    idle_cycles(8, 7);

    // overshoot
    drive(1'b0, 1'b1, 1'b0, 1'b0, 90);
    idle_cycles(8, 255);

    // pause at 40, then kill at 60 held for 3 cycles
    drive(1'b0, 1'b1, 1'b0, 1'b0, 100);
    idle_cycles(2, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle_cycles(2, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle_cycles(3, 0);

    // kill and hold together in ACTIVE
    drive(1'b0, 1'b1, 1'b0, 1'b0, 100);
    idle_cycles(1, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle_cycles(2, 0);

    // limit = 0
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(4, 0);

    // reset mid-job, then an immediate go
    drive(1'b0, 1'b1, 1'b0, 1'b0, 100);
    idle_cycles(3, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 100);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 40);
    idle_cycles(5, 0);

    // go held high: restart behaviour depends on the build option
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 40);
    idle_cycles(3, 0);

    // kill in IDLE is ignored, so go is still accepted
    drive(1'b0, 1'b1, 1'b1, 1'b0, 60);
    idle_cycles(6, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 63) == 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 255)));
    end

    idle_cycles(2, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/job_fsm.md
JOB_FSM -- requirements
Module: job_fsm

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of limit and count.
REQ-002 Parameter STEP, default 20, SHALL set the per-cycle count increment; legal range 1 to 2^WIDTH-1.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port go  input  1  SHALL be the job start request, sampled in IDLE only.
REQ-006 Port kill  input  1  SHALL be the abort request, level-sensitive.
REQ-007 Port hold  input  1  SHALL be the pause request, level-sensitive.
REQ-008 Port limit  input  WIDTH  SHALL be the terminal count, sampled when go is accepted.
REQ-009 Port done  output  1  SHALL be high exactly while state is FINISH.
REQ-010 Port aborted  output  1  SHALL be high exactly while state is ABORT.
REQ-011 Port busy  output  1  SHALL be high while state is ACTIVE or PAUSE.
REQ-012 Port count  output  WIDTH  SHALL expose the progress counter register.

Function
REQ-013 States SHALL be IDLE, ACTIVE, PAUSE, FINISH and ABORT, held in a registered encoding; any unused encoding SHALL return to IDLE on the next edge.
REQ-014 IDLE: count=0; go=1 SHALL move to ACTIVE and capture limit into limit_q on the same edge; go=0 SHALL stay in IDLE.
REQ-015 ACTIVE priority SHALL be kill, then hold, then terminal test.
- kill=1 -> ABORT, count held.
- Else hold=1 -> PAUSE, count held.
- Else if count+STEP >= limit_q -> FINISH, count loaded with limit_q.
- Otherwise count += STEP.
REQ-016 The terminal sum SHALL be computed in WIDTH+1 bits, so count never wraps and never exceeds limit_q.
REQ-017 PAUSE: kill=1 -> ABORT; hold=0 -> ACTIVE; count is held in both cases and while remaining in PAUSE.
REQ-018 FINISH SHALL last exactly one cycle, then go to IDLE with count cleared to 0.
REQ-019 ABORT: count SHALL be cleared to 0 on the first edge in ABORT; the FSM SHALL stay in ABORT while kill=1 and go to IDLE on the first edge with kill=0.
REQ-020 Excluding PAUSE cycles, ACTIVE SHALL last max(1, ceil(limit_q/STEP)) cycles; limit=0 therefore yields one ACTIVE cycle, then FINISH.
REQ-021 go SHALL be ignored outside IDLE (and outside FINISH when REQ-025 applies); limit changes after capture SHALL have no effect.
REQ-022 kill SHALL take priority over hold and go in every state except reset; kill in IDLE or FINISH SHALL be ignored.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, count=0, limit_q=0, done=0, aborted=0, busy=0, overriding all other inputs, including mid-job and mid-ABORT.
REQ-024 After reset is released, the first go SHALL be accepted on the first edge with reset=0.

Configuration
REQ-025 With macro JOB_FSM_AUTO_RESTART_EN defined, FINISH with go=1 SHALL go directly to ACTIVE, recapture limit, and clear count to 0; without it, FINISH SHALL always go to IDLE as in REQ-018.

Verification
REQ-026 Nominal: WIDTH=8, STEP=20, limit=100, go for one cycle -> count 0,20,40,60,80 in ACTIVE, then FINISH with count=100, done high 1 cycle, then IDLE with count=0.
REQ-027 Overshoot: limit=90, STEP=20 -> five ACTIVE cycles, FINISH with count=90 (saturated), done pulse exactly once.
REQ-028 Pause and kill: limit=100, hold high for 3 cycles at count=40 -> count stays 40 and busy=1 for 3 cycles, then resumes; kill at count=60 -> ABORT with aborted=1, count=0, held while kill=1, IDLE one cycle after kill falls, done never asserted.
REQ-029 Edge cases: limit=0 with go -> one ACTIVE cycle, then FINISH with count=0; kill and hold together in ACTIVE -> ABORT.
REQ-030 Reset mid-job at count=60 -> next cycle IDLE, count=0, all outputs 0; go with limit=40 immediately after -> FINISH after 2 ACTIVE cycles.
REQ-031 With JOB_FSM_AUTO_RESTART_EN defined and go held high, limit=40 -> pattern ACTIVE, ACTIVE, FINISH repeats with no IDLE cycle; without the macro, one IDLE cycle between jobs.
